// File: rtl/rr_sel_pkg.sv
// Shared constants, state type and one-hot helper for the round-robin select arbiter.
package rr_sel_pkg;
  localparam int NUM_CH      = 4;
  localparam int SEL_W       = 2;
  localparam int TIMEOUT_MAX = 15;

  typedef enum logic {IDLE, GRANT} state_t;

  function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction
endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority search: first set bit of (req & mask) starting at start, wrapping mod NUM_CH.
module rr_priority_pick import rr_sel_pkg::*; (
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  start,
  output logic [SEL_W-1:0]  idx,
  output logic              found
);
  logic [NUM_CH-1:0] cand;
  logic [SEL_W-1:0]  c;

  assign cand = req & mask;

  // Walk from the farthest offset down so the nearest candidate is written last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    c     = '0;
    for (int k = NUM_CH-1; k >= 0; k--) begin
      c = start + SEL_W'(k);
      if (cand[c]) begin
        idx   = c;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter driving a 4:1 mux select with valid/ready handshake.
// Optional grant-hold timeout enabled by defining RR_HOLD_TIMEOUT_EN.
module rr_sel_arbiter #(
  parameter int NUM_CH      = rr_sel_pkg::NUM_CH,
  parameter int TIMEOUT_MAX = rr_sel_pkg::TIMEOUT_MAX
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            req,
  input  logic                         out_ready,
  output logic [rr_sel_pkg::SEL_W-1:0] sel,
  output logic [NUM_CH-1:0]            grant,
  output logic                         out_valid,
  output logic                         timeout
);
  import rr_sel_pkg::*;

  if (NUM_CH != 4 || TIMEOUT_MAX < 1 || TIMEOUT_MAX > 15) begin : g_bad_cfg
    $error("rr_sel_arbiter: NUM_CH must be 4 and TIMEOUT_MAX must fit a 4-bit counter");
  end

  state_t            state, state_n;
  logic [SEL_W-1:0]  ptr, ptr_n, sel_n, start, pick_idx;
  logic [NUM_CH-1:0] grant_n, mask;
  logic              pick_found, xfer, stall_hit, release_g;

  assign out_valid = (state == GRANT);
  assign xfer      = out_valid & out_ready;

`ifdef RR_HOLD_TIMEOUT_EN
  logic [3:0] stall_cnt;

  assign stall_hit = out_valid & ~out_ready & (stall_cnt == 4'(TIMEOUT_MAX - 1));

  // Counts stalled grant cycles; any other cycle (idle, transfer, forced release) clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      stall_cnt <= (out_valid & ~out_ready & ~stall_hit) ? stall_cnt + 4'd1 : 4'd0;
      timeout   <= stall_hit;
    end
  end
`else
  assign stall_hit = 1'b0;
  assign timeout   = 1'b0;
`endif

  assign release_g = xfer | stall_hit;

  // Idle searches from ptr over everyone; a release searches past the current owner.
  assign start = (state == IDLE) ? ptr : sel + 1'b1;
  assign mask  = (state == IDLE) ? '1 : ~grant;

  rr_priority_pick u_pick (
    .req   (req),
    .mask  (mask),
    .start (start),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_n = state;
    sel_n   = sel;
    grant_n = grant;
    ptr_n   = ptr;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_n = GRANT;
          sel_n   = pick_idx;
          grant_n = onehot(pick_idx);
        end
      end
      GRANT: begin
        if (release_g) begin
          ptr_n = sel + 1'b1;
          if (pick_found) begin
            sel_n   = pick_idx;
            grant_n = onehot(pick_idx);
          end else if (!req[sel]) begin
            state_n = IDLE;
            grant_n = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel   <= '0;
      grant <= '0;
      ptr   <= '0;
    end else begin
      state <= state_n;
      sel   <= sel_n;
      grant <= grant_n;
      ptr   <= ptr_n;
    end
  end
endmodule

// File: doc/rr_sel_arbiter.md
RR_SEL_ARBITER -- requirements
Module: rr_sel_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 4, number of request channels (fixed at 4 in this revision).
REQ-002 The module SHALL have parameter TIMEOUT_MAX, default 15, stall-cycle limit used only under RR_HOLD_TIMEOUT_EN.
REQ-003 The module SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-004 The module SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The module SHALL have port req  input  4  bit i high means channel i has a word pending on 4:1 mux data input i.
REQ-006 The module SHALL have port out_ready  input  1  downstream accepts the mux output this cycle.
REQ-007 The module SHALL have port sel  output  2  registered select driven straight onto the downstream 4:1 8-bit mux sel input.
REQ-008 The module SHALL have port grant  output  4  registered one-hot copy of sel, all-zero when idle.
REQ-009 The module SHALL have port out_valid  output  1  mux output is valid for the channel selected by sel.
REQ-010 The module SHALL have port timeout  output  1  one-cycle pulse on forced grant release.

Function
REQ-011 The FSM SHALL have exactly two states, IDLE (out_valid=0, grant=0) and GRANT (out_valid=1, grant=1<<sel).
REQ-012 In IDLE with req!=0, the FSM SHALL enter GRANT on the next edge, with sel equal to the first set req bit searched from ptr upward, mod 4.
REQ-013 Latency from req assertion in IDLE to out_valid SHALL be exactly 1 cycle.
REQ-014 A transfer SHALL occur on any edge where out_valid and out_ready are both high; one transfer per grant.
REQ-015 On a transfer, ptr SHALL become (sel+1) mod 4.
REQ-016 On a transfer, if req masked by ~grant is nonzero, the FSM SHALL stay in GRANT and load the next sel searched from (sel+1) mod 4, giving back-to-back transfers with no idle cycle.
REQ-017 On a transfer with no other requester, the FSM SHALL load the granted channel again if its req is still high, else go to IDLE.
REQ-018 In GRANT without out_ready, sel, grant and out_valid SHALL hold unchanged, even if the granted channel drops req.
REQ-019 sel and grant SHALL NOT change while out_valid=1 and out_ready=0, except on a timeout.
REQ-020 With all four req high continuously and out_ready=1, the grant order SHALL be 0,1,2,3,0,... with wrap-around from 3 to 0.
REQ-021 timeout SHALL be 0 in every cycle unless RR_HOLD_TIMEOUT_EN is defined.

Reset
REQ-022 While rst is high at a clock edge, the next state SHALL be IDLE with sel=0, grant=0, out_valid=0, timeout=0, ptr=0 and stall counter=0, overriding any in-flight grant.
REQ-023 After reset release, the first arbitration SHALL give channel 0 highest priority.

Configuration
REQ-024 With macro RR_HOLD_TIMEOUT_EN defined, a 4-bit stall counter SHALL increment each GRANT cycle with out_ready=0 and clear on transfer or on entry to a new grant.
REQ-025 With RR_HOLD_TIMEOUT_EN defined, when the counter reaches TIMEOUT_MAX the block SHALL pulse timeout for 1 cycle, set ptr=(sel+1) mod 4, and re-arbitrate as on a transfer without counting one.
REQ-026 Without RR_HOLD_TIMEOUT_EN, the counter SHALL NOT be present, timeout SHALL be tied 0, and a grant SHALL hold indefinitely.

Structure
REQ-027 Package rr_sel_pkg SHALL hold NUM_CH, SEL_W=2, TIMEOUT_MAX, and the state typedef {IDLE, GRANT}.
REQ-028 Sub-module rr_priority_pick SHALL be the only sub-module: combinational, inputs req[3:0], mask[3:0] and start[1:0], outputs idx[1:0] and found.

Verification
REQ-029 The bench SHALL cover reset: rst=1 for 2 cycles with req=4'hF -> sel=0, grant=0, out_valid=0; first grant after release is channel 0.
REQ-030 The bench SHALL cover full rotation: req=4'hF, out_ready=1 for 8 cycles -> sel sequence 0,1,2,3,0,1,2,3 with out_valid constantly 1.
REQ-031 The bench SHALL cover backpressure: req=4'b0100, out_ready=0 for 5 cycles, then req dropped and out_ready=1 -> sel=2 held for 5 cycles, one transfer, then IDLE.
REQ-032 The bench SHALL cover skip: ptr=1, req=4'b1001 -> grant channel 3 then channel 0.
REQ-033 The bench SHALL cover reset mid-grant: rst=1 during GRANT with sel=3 -> next cycle out_valid=0, sel=0.
REQ-034 The bench SHALL cover timeout with RR_HOLD_TIMEOUT_EN defined: req=4'b0011, out_ready=0 -> after 15 stall cycles timeout=1 for one cycle and sel changes from 0 to 1.
